spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- Byte-oriented SPI slave (target) running entirely in the system clock domain. It oversamples the SPI pins.
- Deserialises MOSI into bytes, with a one-cycle valid pulse per received byte.
- Serialises a host-supplied byte onto MISO during the following byte slot.
- Sits between the SPI pins and a command/protocol FSM, such as a serial-flash model.

Parameters:
- SPI_MODE, 0, SPI mode 0..3. CPOL = SPI_MODE[1] (idle SCK level). CPHA = SPI_MODE[0] (0: sample on leading edge; 1: sample on trailing edge).

Ports:
- i_Clk  in  1  system clock; all logic on its rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- o_RX_DV  out  1  one-cycle pulse: o_RX_Byte holds a new byte.
- o_RX_Byte  out  8  last complete received byte, MSB first.
- i_TX_DV  in  1  one-cycle strobe: load i_TX_Byte into the TX buffer.
- i_TX_Byte  in  8  byte to transmit in the next byte slot.
- i_SPI_Clk  in  1  SPI SCK; asynchronous to i_Clk.
- o_SPI_MISO  out  1  serial data out, MSB first.
- i_SPI_MOSI  in  1  serial data in.
- i_SPI_CS_n  in  1  active-low chip select.

Behaviour:
- Clocking: one clock domain, i_Clk, with synchronous active-high reset i_Rst. i_Clk must be at least 8× SCK frequency.
- Synchronisation: SCK, MOSI and CS_n each pass through a 2-FF synchroniser. Edges are detected on the synchronised signals by comparing with their previous value.
- Leading/trailing edge: the leading edge is the edge leaving the CPOL idle level; the trailing edge is the return to it.
- Sample edge: leading edge if CPHA=0, trailing edge if CPHA=1.
- Shift edge: the opposite edge to the sample edge.
- Reset values: o_RX_DV=0, o_RX_Byte=8'h00, o_SPI_MISO=1, bit counter=0, TX buffer=8'hFF, TX-valid flag=0.
- Reset mid-transfer aborts the transfer: no o_RX_DV is emitted and the partial byte is discarded.
- CS_n high: bit counter held at 0, RX shift register cleared, o_SPI_MISO driven 1, SCK edges ignored.
- Receive:
  - On each sample edge with CS_n low, shift MOSI into the RX shift register LSB and increment the 3-bit counter.
  - On the 8th sample, on the next i_Clk: o_RX_Byte takes the full byte and o_RX_DV pulses high for exactly one cycle. The counter wraps to 0.
  - Bytes in one CS_n-low frame are back-to-back and unlimited.
- TX buffer:
  - i_TX_DV=1 writes i_TX_Byte to the buffer and sets the TX-valid flag.
  - A later i_TX_DV before the next load overwrites the buffer; the last write wins.
- TX load point:
  - The TX shift register is loaded at each byte start: CS_n falling edge, or the cycle the counter wraps to 0 while CS_n stays low.
  - Loaded value is the buffer if TX-valid=1, else 8'hFF. The TX-valid flag is cleared on load.
  - If i_TX_DV coincides with a load, the new i_TX_Byte is loaded directly.
- TX output, CPHA=0: the MSB is presented on MISO at the load point. Each shift edge advances to the next bit.
- TX output, CPHA=1: MISO updates to the next bit on each shift (leading) edge, starting with the MSB at the first leading edge.
- Byte ordering: a byte supplied via i_TX_DV in response to o_RX_DV of byte N is sent during byte N+1.
- MISO latency: MISO changes within 4 i_Clk cycles of the SCK shift edge.
- CS_n rising mid-byte: counter reset to 0, no o_RX_DV, TX shift register discarded. The TX buffer and TX-valid flag are retained.
- Glitch handling: SCK toggling while CS_n is high has no effect.

Decomposition:
- Shared package: SPI_MODE decode constants (CPOL/CPHA bit positions), idle MISO level (1), default TX fill byte (8'hFF).
- Sub-module `spi_sync_edge`: 2-FF synchroniser plus rise/fall detect. Instantiated three times (SCK, MOSI, CS_n).
- Keep RX/TX shift logic in the top module.

Test Plan:
- Mode 0, CS low, MOSI sends 8'h03 → exactly one o_RX_DV pulse, o_RX_Byte=8'h03; MISO during that byte = 8'hFF (no TX loaded).
- Mode 0, bytes 8'h03, 8'h00, 8'h10, 8'h00 back-to-back; after the 4th o_RX_DV, i_TX_DV with i_TX_Byte=8'hA5 → 5th byte MISO shows 8'hA5 MSB first, 5th o_RX_Byte as sent.
- Modes 1, 2, 3 each: master sends 8'h5A while slave preloads 8'hC3 before CS fall → o_RX_Byte=8'h5A and master samples 8'hC3.
- CS_n raised after 5 SCK cycles, then a new frame sending 8'h81 → no o_RX_DV for the partial byte; the next byte reads 8'h81.
- Two i_TX_DV strobes (8'h11 then 8'h22) before a byte start → 8'h22 transmitted; the following byte with no strobe → 8'hFF.
- i_Rst asserted mid-byte → o_RX_DV=0, o_RX_Byte=8'h00, MISO=1; next full byte 8'hE7 after reset is received correctly.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared constants and mode decoding for the oversampling SPI slave.
package spi_slave_pkg;

    localparam int unsigned CPOL_BIT  = 1;
    localparam int unsigned CPHA_BIT  = 0;
    localparam logic        MISO_IDLE = 1'b1;
    localparam logic [7:0]  TX_FILL   = 8'hFF;
    localparam logic [2:0]  LAST_BIT  = 3'd7;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    function automatic spi_mode_t decode_mode(input logic [1:0] mode);
        spi_mode_t m;
        m.cpol = mode[CPOL_BIT];
        m.cpha = mode[CPHA_BIT];
        return m;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one SPI pin with rise/fall detection on the
// synchronised level.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser chain plus one delayed copy for edge comparison.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI slave oversampling SCK/MOSI/CS_n in the i_Clk domain;
// received bytes are strobed out, a host-supplied byte is shifted on MISO.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned SPI_MODE = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_SPI_Clk,
    output logic       o_SPI_MISO,
    input  logic       i_SPI_MOSI,
    input  logic       i_SPI_CS_n
);

    localparam spi_mode_t MODE = decode_mode(SPI_MODE[1:0]);
    localparam logic      CPOL = MODE.cpol;
    localparam logic      CPHA = MODE.cpha;

    logic sck_rise_s, sck_fall_s, sck_level_s;
    logic mosi_s, mosi_rise_s, mosi_fall_s;
    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic unused_edges_s;

    spi_sync_edge #(.RESET_VAL(CPOL)) u_sync_sck (
        .clk_i(i_Clk), .rst_i(i_Rst), .async_i(i_SPI_Clk),
        .level_o(sck_level_s), .rise_o(sck_rise_s), .fall_o(sck_fall_s)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i(i_Clk), .rst_i(i_Rst), .async_i(i_SPI_MOSI),
        .level_o(mosi_s), .rise_o(mosi_rise_s), .fall_o(mosi_fall_s)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk_i(i_Clk), .rst_i(i_Rst), .async_i(i_SPI_CS_n),
        .level_o(cs_level_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s)
    );

    assign unused_edges_s = ^{sck_level_s, mosi_rise_s, mosi_fall_s, cs_rise_s};

    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_dv_q, rx_dv_d;
    logic       miso_q, miso_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       tx_valid_q, tx_valid_d;
    logic       tx_open_q, tx_open_d;

    logic       cs_active_s, lead_s, trail_s, sample_s, shift_s;
    logic       load_s, reload_s, advance_s;
    logic [7:0] tx_next_s;

    assign cs_active_s = ~cs_level_s;
    assign lead_s      = CPOL ? sck_fall_s : sck_rise_s;
    assign trail_s     = CPOL ? sck_rise_s : sck_fall_s;
    assign sample_s    = CPHA ? trail_s : lead_s;
    assign shift_s     = CPHA ? lead_s : trail_s;

    assign load_s    = cs_active_s & (cs_fall_s | (sample_s & (cnt_q == LAST_BIT)));
    // Until the first leading edge commits the MSB, a fresh strobe still
    // replaces the byte just loaded, so a reply to byte N lands in byte N+1.
    assign reload_s  = cs_active_s & tx_open_q & ~lead_s & ~load_s & i_TX_DV;
    // With CPHA=0 the trailing edge after the 8th sample belongs to the old
    // byte; the new MSB is already on MISO, so that edge must not shift.
    assign advance_s = cs_active_s & shift_s & (CPHA | (cnt_q != 3'd0)) & ~load_s;
    assign tx_next_s = i_TX_DV ? i_TX_Byte : (tx_valid_q ? tx_buf_q : TX_FILL);

    // Receive shifting, byte strobe, and MISO serialisation.
    always_comb begin
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;
        miso_d     = miso_q;
        tx_shift_d = tx_shift_q;
        tx_open_d  = tx_open_q;
        if (!cs_active_s) begin
            cnt_d      = 3'd0;
            rx_shift_d = 8'h00;
            miso_d     = MISO_IDLE;
            tx_shift_d = TX_FILL;
            tx_open_d  = 1'b0;
        end else begin
            if (sample_s) begin
                rx_shift_d = {rx_shift_q[6:0], mosi_s};
                cnt_d      = cnt_q + 3'd1;
                if (cnt_q == LAST_BIT) begin
                    rx_byte_d = {rx_shift_q[6:0], mosi_s};
                    rx_dv_d   = 1'b1;
                end else begin
                    rx_dv_d   = 1'b0;
                end
            end else begin
                rx_dv_d = 1'b0;
            end

            if (load_s) begin
                tx_shift_d = tx_next_s;
                miso_d     = CPHA ? miso_q : tx_next_s[7];
            end else if (reload_s) begin
                tx_shift_d = i_TX_Byte;
                miso_d     = CPHA ? miso_q : i_TX_Byte[7];
            end else if (advance_s) begin
                miso_d     = CPHA ? tx_shift_q[7] : tx_shift_q[6];
                tx_shift_d = {tx_shift_q[6:0], 1'b1};
            end else begin
                tx_shift_d = tx_shift_q;
            end

            if (load_s) begin
                tx_open_d = 1'b1;
            end else if (lead_s) begin
                tx_open_d = 1'b0;
            end else begin
                tx_open_d = tx_open_q;
            end
        end
    end

    // TX buffer: strobes not consumed directly by a load are held for later.
    always_comb begin
        tx_buf_d   = tx_buf_q;
        tx_valid_d = tx_valid_q;
        if (i_TX_DV && !load_s && !reload_s) begin
            tx_buf_d   = i_TX_Byte;
            tx_valid_d = 1'b1;
        end else if (load_s) begin
            tx_valid_d = 1'b0;
        end else begin
            tx_valid_d = tx_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q      <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_dv_q    <= 1'b0;
            miso_q     <= MISO_IDLE;
            tx_shift_q <= TX_FILL;
            tx_buf_q   <= TX_FILL;
            tx_valid_q <= 1'b0;
            tx_open_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_dv_q    <= rx_dv_d;
            miso_q     <= miso_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_valid_q <= tx_valid_d;
            tx_open_q  <= tx_open_d;
        end
    end

    assign o_RX_DV    = rx_dv_q;
    assign o_RX_Byte  = rx_byte_q;
    assign o_SPI_MISO = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// Randomised and directed bench for spi_slave in all four SPI modes, with a
// byte-level reference model of what the master should see.
module tb_spi_slave;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       sck;
    logic       mosi;
    logic       cs_n;
    logic [3:0] rx_dv;
    logic [3:0] miso;
    logic [7:0] rx_byte [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.SPI_MODE(g)) u_dut (
            .i_Clk(clk), .i_Rst(rst),
            .o_RX_DV(rx_dv[g]), .o_RX_Byte(rx_byte[g]),
            .i_TX_DV(tx_dv), .i_TX_Byte(tx_byte),
            .i_SPI_Clk(sck), .o_SPI_MISO(miso[g]),
            .i_SPI_MOSI(mosi), .i_SPI_CS_n(cs_n)
        );
    end

    int         errors = 0;
    int         checks = 0;
    logic [1:0] cur_mode = 2'd0;
    logic [7:0] rx_seen [$];
    logic [7:0] mosi_bytes [8];
    logic [7:0] miso_got [8];
    logic [7:0] resp_byte [8];
    bit         resp_has [8];

    always @(negedge clk) begin
        if (rx_dv[cur_mode]) rx_seen.push_back(rx_byte[cur_mode]);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        tx_byte = b;
        tx_dv   = 1'b1;
        @(negedge clk);
        tx_dv   = 1'b0;
    endtask

    task automatic clear_resp();
        for (int k = 0; k < 8; k++) begin
            resp_has[k]  = 1'b0;
            resp_byte[k] = 8'h00;
        end
    endtask

    task automatic master_bits(input logic [1:0] mode, input logic [7:0] data,
                               input int nbits, input int slot);
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!mode[0]) begin
                mosi = data[i];
                #(HALF);
                miso_got[slot][i] = miso[mode];
                sck = ~mode[1];
                #(HALF);
                sck = mode[1];
            end else begin
                #(HALF);
                sck  = ~mode[1];
                mosi = data[i];
                #(HALF);
                miso_got[slot][i] = miso[mode];
                sck = mode[1];
            end
        end
    endtask

    task automatic master_frame(input logic [1:0] mode, input int n);
        cs_n = 1'b0;
        #(HALF);
        for (int b = 0; b < n; b++) master_bits(mode, mosi_bytes[b], 8, b);
        #(HALF);
        cs_n = 1'b1;
        #(HALF);
    endtask

    task automatic host_responder(input int n);
        for (int k = 0; k < n; k++) begin
            int waited = 0;
            bit seen = 1'b0;
            while (!seen && waited < 400) begin
                @(negedge clk);
                waited++;
                seen = rx_dv[cur_mode];
            end
            if (!seen) break;
            if (resp_has[k]) begin
                tx_byte = resp_byte[k];
                tx_dv   = 1'b1;
                @(negedge clk);
                tx_dv   = 1'b0;
            end
        end
    endtask

    task automatic run_frame(input logic [1:0] mode, input int n);
        cur_mode = mode;
        sck = mode[1];
        repeat (4) @(negedge clk);
        rx_seen.delete();
        fork
            master_frame(mode, n);
            host_responder(n);
        join
    endtask

    task automatic test_reset();
        do_reset();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (rx_dv[g[1:0]] !== 1'b0) begin
                errors++; $display("FAIL reset_rx_dv m%0d: got %b expected 0", g, rx_dv[g[1:0]]);
            end
            checks++;
            if (rx_byte[g] !== 8'h00) begin
                errors++; $display("FAIL reset_rx_byte m%0d: got %h expected 00", g, rx_byte[g]);
            end
            checks++;
            if (miso[g[1:0]] !== 1'b1) begin
                errors++; $display("FAIL reset_miso m%0d: got %b expected 1", g, miso[g[1:0]]);
            end
        end
    endtask

    task automatic test_single_byte();
        do_reset();
        clear_resp();
        mosi_bytes[0] = 8'h03;
        run_frame(2'd0, 1);
        checks++;
        if (rx_seen.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d pulses expected 1", rx_seen.size());
        end
        checks++;
        if (rx_seen.size() < 1 || rx_seen[0] !== 8'h03) begin
            errors++; $display("FAIL single_rx: got %h expected 03", rx_seen.size() > 0 ? rx_seen[0] : 8'hxx);
        end
        checks++;
        if (miso_got[0] !== 8'hFF) begin
            errors++; $display("FAIL single_miso: got %h expected ff", miso_got[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_miso;
        do_reset();
        clear_resp();
        mosi_bytes[0] = 8'h03; mosi_bytes[1] = 8'h00;
        mosi_bytes[2] = 8'h10; mosi_bytes[3] = 8'h00;
        mosi_bytes[4] = 8'($urandom_range(0, 255));
        resp_has[3]  = 1'b1;
        resp_byte[3] = 8'hA5;
        run_frame(2'd0, 5);
        checks++;
        if (rx_seen.size() != 5) begin
            errors++; $display("FAIL b2b_count: got %0d pulses expected 5", rx_seen.size());
        end
        for (int b = 0; b < 5; b++) begin
            exp_miso = (b == 4) ? 8'hA5 : 8'hFF;
            checks++;
            if (b >= rx_seen.size() || rx_seen[b] !== mosi_bytes[b]) begin
                errors++; $display("FAIL b2b_rx%0d: got %h expected %h", b, b < rx_seen.size() ? rx_seen[b] : 8'hxx, mosi_bytes[b]);
            end
            checks++;
            if (miso_got[b] !== exp_miso) begin
                errors++; $display("FAIL b2b_miso%0d: got %h expected %h", b, miso_got[b], exp_miso);
            end
        end
    endtask

    task automatic test_modes();
        for (int m = 1; m < 4; m++) begin
            do_reset();
            clear_resp();
            cur_mode = 2'(m);
            sck = cur_mode[1];
            strobe(8'hC3);
            mosi_bytes[0] = 8'h5A;
            run_frame(2'(m), 1);
            checks++;
            if (rx_seen.size() != 1) begin
                errors++; $display("FAIL mode%0d_count: got %0d pulses expected 1", m, rx_seen.size());
            end
            checks++;
            if (rx_seen.size() < 1 || rx_seen[0] !== 8'h5A) begin
                errors++; $display("FAIL mode%0d_rx: got %h expected 5a", m, rx_seen.size() > 0 ? rx_seen[0] : 8'hxx);
            end
            checks++;
            if (miso_got[0] !== 8'hC3) begin
                errors++; $display("FAIL mode%0d_miso: got %h expected c3", m, miso_got[0]);
            end
        end
    endtask

    task automatic test_cs_abort();
        do_reset();
        clear_resp();
        cur_mode = 2'd0;
        sck = 1'b0;
        repeat (4) @(negedge clk);
        rx_seen.delete();
        cs_n = 1'b0;
        #(HALF);
        master_bits(2'd0, 8'hB6, 5, 0);
        #(HALF);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (rx_seen.size() != 0) begin
            errors++; $display("FAIL abort_no_dv: got %0d pulses expected 0", rx_seen.size());
        end
        checks++;
        if (miso[0] !== 1'b1) begin
            errors++; $display("FAIL abort_miso_idle: got %b expected 1", miso[0]);
        end
        mosi_bytes[0] = 8'h81;
        run_frame(2'd0, 1);
        checks++;
        if (rx_seen.size() != 1 || rx_seen[0] !== 8'h81) begin
            errors++; $display("FAIL abort_next_rx: got %0d pulses first %h expected 1 pulse 81", rx_seen.size(), rx_seen.size() > 0 ? rx_seen[0] : 8'hxx);
        end
    endtask

    task automatic test_double_strobe();
        do_reset();
        clear_resp();
        cur_mode = 2'd0;
        sck = 1'b0;
        strobe(8'h11);
        strobe(8'h22);
        mosi_bytes[0] = 8'h6C;
        mosi_bytes[1] = 8'h93;
        run_frame(2'd0, 2);
        checks++;
        if (miso_got[0] !== 8'h22) begin
            errors++; $display("FAIL dbl_last_wins: got %h expected 22", miso_got[0]);
        end
        checks++;
        if (miso_got[1] !== 8'hFF) begin
            errors++; $display("FAIL dbl_fill: got %h expected ff", miso_got[1]);
        end
        checks++;
        if (rx_seen.size() != 2 || rx_seen[1] !== 8'h93) begin
            errors++; $display("FAIL dbl_rx: got %0d pulses last %h expected 2 pulses 93", rx_seen.size(), rx_seen.size() > 1 ? rx_seen[1] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid();
        clear_resp();
        cur_mode = 2'd0;
        sck = 1'b0;
        repeat (4) @(negedge clk);
        rx_seen.delete();
        cs_n = 1'b0;
        #(HALF);
        master_bits(2'd0, 8'h3C, 4, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_dv[0] !== 1'b0) begin
            errors++; $display("FAIL rstmid_dv: got %b expected 0", rx_dv[0]);
        end
        checks++;
        if (rx_byte[0] !== 8'h00) begin
            errors++; $display("FAIL rstmid_byte: got %h expected 00", rx_byte[0]);
        end
        checks++;
        if (miso[0] !== 1'b1) begin
            errors++; $display("FAIL rstmid_miso: got %b expected 1", miso[0]);
        end
        @(negedge clk);
        rst  = 1'b0;
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (rx_seen.size() != 0) begin
            errors++; $display("FAIL rstmid_no_dv: got %0d pulses expected 0", rx_seen.size());
        end
        mosi_bytes[0] = 8'hE7;
        run_frame(2'd0, 1);
        checks++;
        if (rx_seen.size() != 1 || rx_seen[0] !== 8'hE7) begin
            errors++; $display("FAIL rstmid_next_rx: got %0d pulses first %h expected 1 pulse e7", rx_seen.size(), rx_seen.size() > 0 ? rx_seen[0] : 8'hxx);
        end
    endtask

    task automatic test_random();
        logic [1:0] mode;
        logic [7:0] pre_byte;
        logic [7:0] exp_miso;
        bit         pre;
        int         n;
        for (int f = 0; f < 6; f++) begin
            mode = 2'($urandom_range(0, 3));
            n    = $urandom_range(1, 4);
            pre  = 1'($urandom_range(0, 1));
            pre_byte = 8'($urandom_range(0, 255));
            do_reset();
            clear_resp();
            cur_mode = mode;
            sck = mode[1];
            for (int b = 0; b < n; b++) begin
                mosi_bytes[b] = 8'($urandom_range(0, 255));
                resp_has[b]   = 1'($urandom_range(0, 1));
                resp_byte[b]  = 8'($urandom_range(0, 255));
            end
            if (pre) strobe(pre_byte);
            run_frame(mode, n);
            checks++;
            if (rx_seen.size() != n) begin
                errors++; $display("FAIL rnd%0d_count: got %0d pulses expected %0d (mode %0d)", f, rx_seen.size(), n, mode);
            end
            for (int b = 0; b < n; b++) begin
                if (b == 0) exp_miso = pre ? pre_byte : 8'hFF;
                else        exp_miso = resp_has[b-1] ? resp_byte[b-1] : 8'hFF;
                checks++;
                if (b >= rx_seen.size() || rx_seen[b] !== mosi_bytes[b]) begin
                    errors++; $display("FAIL rnd%0d_rx%0d: got %h expected %h (mode %0d)", f, b, b < rx_seen.size() ? rx_seen[b] : 8'hxx, mosi_bytes[b], mode);
                end
                checks++;
                if (miso_got[b] !== exp_miso) begin
                    errors++; $display("FAIL rnd%0d_miso%0d: got %h expected %h (mode %0d)", f, b, miso_got[b], exp_miso, mode);
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        tx_dv   = 1'b0;
        tx_byte = 8'h00;
        sck     = 1'b0;
        mosi    = 1'b0;
        cs_n    = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_modes();
        test_cs_abort();
        test_double_strobe();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
